// File: rtl/irq_ctrl.sv
// Interrupt controller: masks level requests, arbitrates one winner, handshakes with the CPU
// and issues the clear write (offset 2'b01) to the winning peripheral. IRQ_CTRL_RR_EN adds round-robin.
module irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,

    input  logic             i_sel,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [1:0]       i_addr,
    input  logic [15:0]      i_wdata,
    output logic [15:0]      o_rdata,
    output logic             o_rdy,

    input  logic [N_SRC-1:0] i_src_req,

    output logic             o_cpu_irq,
    output logic [VEC_W-1:0] o_cpu_vec,
    input  logic             i_cpu_ack,

    output logic [N_SRC-1:0] o_clr_sel,
    output logic             o_clr_we,
    output logic [1:0]       o_clr_addr,
    output logic [15:0]      o_clr_wdata,
    input  logic             i_clr_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   mask_q;
    logic               en_q;
    logic [N_SRC-1:0]   pend;
    logic [VEC_W-1:0]   win_idx;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [N_SRC-1:0]   vec_onehot;
    logic               irq_q, irq_d;
    logic               clr_we_q, clr_we_d;
    logic [N_SRC-1:0]   clr_sel_q, clr_sel_d;
    logic               reg_wr;
    logic [15:0]        status;
    logic               unused_wdata;

    assign reg_wr       = i_sel && i_we;
    assign pend         = i_src_req & mask_q;
    assign vec_onehot   = {{(N_SRC-1){1'b0}}, 1'b1} << vec_q;
    assign unused_wdata = ^i_wdata;

`ifdef IRQ_CTRL_RR_EN
    logic               rr_q;
    logic [VEC_W-1:0]   last_q, last_d;
    logic [VEC_W-1:0]   rr_idx;

    // Walk the search order backwards so the last hit written is the first in priority order.
    always_comb begin
        win_idx = '0;
        rr_idx  = '0;
        if (rr_q) begin
            for (int k = N_SRC; k >= 1; k--) begin
                rr_idx = VEC_W'((int'(last_q) + k) % N_SRC);
                if (pend[rr_idx]) win_idx = rr_idx;
            end
        end else begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (pend[i]) win_idx = VEC_W'(i);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) win_idx = VEC_W'(i);
        end
    end
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        irq_d     = 1'b0;
        clr_we_d  = 1'b0;
        clr_sel_d = '0;
`ifdef IRQ_CTRL_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (en_q && (|pend)) begin
                    state_d = REQ;
                    vec_d   = win_idx;
                    irq_d   = 1'b1;
                end
            end
            REQ: begin
                if (i_cpu_ack) begin
                    state_d   = CLR;
                    clr_we_d  = 1'b1;
                    clr_sel_d = vec_onehot;
`ifdef IRQ_CTRL_RR_EN
                    last_d    = vec_q;
`endif
                end else if (!pend[vec_q] || !en_q) begin
                    state_d = IDLE;
                end else begin
                    irq_d = 1'b1;
                end
            end
            CLR: begin
                if (i_clr_rdy) begin
                    state_d = WAIT;
                end else begin
                    clr_we_d  = 1'b1;
                    clr_sel_d = vec_onehot;
                end
            end
            WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            irq_q     <= 1'b0;
            clr_we_q  <= 1'b0;
            clr_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            irq_q     <= irq_d;
            clr_we_q  <= clr_we_d;
            clr_sel_q <= clr_sel_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mask_q <= '0;
            en_q   <= 1'b0;
`ifdef IRQ_CTRL_RR_EN
            rr_q   <= 1'b0;
            last_q <= VEC_W'(N_SRC - 1);
`endif
        end else begin
            if (reg_wr && (i_addr == 2'b00)) mask_q <= i_wdata[N_SRC-1:0];
            if (reg_wr && (i_addr == 2'b01)) begin
                en_q <= i_wdata[0];
`ifdef IRQ_CTRL_RR_EN
                rr_q <= i_wdata[1];
`endif
            end
`ifdef IRQ_CTRL_RR_EN
            last_q <= last_d;
`endif
        end
    end

    always_comb begin
        status                    = '0;
        status[0]                 = irq_q;
        status[VEC_W:1]           = vec_q;
        status[VEC_W+2:VEC_W+1]   = state_q;
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel && i_re) begin
            case (i_addr)
                2'b00: o_rdata = 16'(mask_q);
`ifdef IRQ_CTRL_RR_EN
                2'b01: o_rdata = {14'b0, rr_q, en_q};
`else
                2'b01: o_rdata = {14'b0, 1'b0, en_q};
`endif
                2'b10: o_rdata = 16'(pend);
                default: o_rdata = status;
            endcase
        end
    end

    assign o_rdy       = i_sel;
    assign o_cpu_irq   = irq_q;
    assign o_cpu_vec   = vec_q;
    assign o_clr_sel   = clr_sel_q;
    assign o_clr_we    = clr_we_q;
    assign o_clr_addr  = 2'b01;
    assign o_clr_wdata = 16'h0000;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller sitting between the memory-mapped peripherals (timers and similar `o_int_req` sources) and the CPU interrupt input.
- Samples up to `N_SRC` level interrupt requests, applies a mask, and selects one winner (fixed or round-robin priority).
- Presents the winner as `o_cpu_irq`/`o_cpu_vec` and waits for the CPU acknowledge.
- After the acknowledge, issues the clear write (offset `2'b01`) to the winning peripheral over a dedicated master port.

## Interface
Parameters:
- `N_SRC`, 4, number of request sources (2..8)
- `VEC_W`, 2, vector width, equal to clog2(`N_SRC`)

Ports:
- **Clock and reset**
  - `i_clk` in 1: single clock.
  - `i_rst` in 1: reset, synchronous, active-high.
- **CPU register port**
  - `i_sel`, `i_we`, `i_re` in 1 each: register port select, write strobe, read strobe.
  - `i_addr` in 2: register offset.
  - `i_wdata` in 16: write data.
  - `o_rdata` out 16: combinational read data; 0 when `!i_sel || !i_re`.
  - `o_rdy` out 1: equals `i_sel`.
- **Request inputs**
  - `i_src_req` in `N_SRC`: level requests from peripherals.
- **CPU interrupt handshake**
  - `o_cpu_irq` out 1: interrupt to CPU.
  - `o_cpu_vec` out `VEC_W`: winning source index, valid while `o_cpu_irq`.
  - `i_cpu_ack` in 1: one-cycle acknowledge from CPU.
- **Clear master port**
  - `o_clr_sel` out `N_SRC`: one-hot peripheral select during the clear.
  - `o_clr_we` out 1: clear write strobe.
  - `o_clr_addr` out 2: constant `2'b01`.
  - `o_clr_wdata` out 16: constant `16'h0000`.
  - `i_clr_rdy` in 1: `o_rdy` of the selected peripheral, muxed externally.

## Operation
- **Registers** (writes need `i_sel && i_we`):
  - `00` MASK[`N_SRC`-1:0]: R/W, reset 0.
  - `01` CTRL: bit0 EN (global enable), bit1 RR (round-robin select). R/W, reset 0.
  - `10` PEND: `i_src_req & MASK`. Read-only; writes ignored.
  - `11` STATUS: {state[1:0] at [VEC_W+2:VEC_W+1], `o_cpu_vec`, `o_cpu_irq` at bit0}. Read-only.
- **Arbitration** over `PEND`, only when EN=1:
  - RR=0: lowest index wins.
  - RR=1: search starts at `last+1` mod `N_SRC`. `last` is updated on entry to CLR and resets to `N_SRC`-1.
- **FSM** `IDLE(0)`, `REQ(1)`, `CLR(2)`, `WAIT(3)`:
  - IDLE: if EN and PEND≠0, latch winner into `o_cpu_vec` and go to REQ. `i_cpu_ack` is ignored.
  - REQ: `o_cpu_irq`=1.
    - `i_cpu_ack` → CLR. Ack has priority over withdrawal in the same cycle.
    - Else if the winner's PEND bit is 0 or EN=0 → IDLE with `o_cpu_irq` dropped (withdrawal, no clear issued).
  - CLR: `o_clr_sel`=onehot(vec), `o_clr_we`=1. Both are held until `i_clr_rdy`=1 is sampled, then → WAIT.
  - WAIT: one cycle, all outputs idle, so the peripheral's registered request can fall. Then → IDLE.
- MASK and CTRL writes during REQ/CLR/WAIT take effect immediately for arbitration. The latched vec is unchanged.
- Writes to PEND/STATUS have no effect.

## Timing
- Reset: `o_cpu_irq`=0, `o_cpu_vec`=0, `o_clr_sel`=0, `o_clr_we`=0, state=IDLE, MASK=0, CTRL=0.
- Request sampled high in IDLE at edge t → `o_cpu_irq`=1 after edge t+1. All handshake outputs are registered.
- `i_cpu_ack` sampled at edge a → `o_clr_we`/`o_clr_sel` high from edge a+1.
- With `i_clr_rdy` already high, the clear lasts exactly one cycle, followed by one WAIT cycle.
- Earliest next `o_cpu_irq` is 3 cycles after the clear cycle.
- Reset in any state → IDLE next edge. A clear in progress is abandoned, not completed.
- Ack pulse wider than one cycle: only the first cycle is used; extra cycles fall in CLR/WAIT and are ignored.

## Configuration
- `IRQ_CTRL_RR_EN` defined: round-robin logic and the `last` pointer are compiled in; CTRL bit1 is writable.
- `IRQ_CTRL_RR_EN` undefined: fixed priority only; CTRL bit1 reads 0 and writes to it are ignored.

## Test plan
- Reset, MASK=`4'hF`, CTRL=1, `i_src_req`=`4'b0100` → `o_cpu_irq`=1, `o_cpu_vec`=2 one cycle later.
- Ack while `i_clr_rdy`=1 → one cycle `o_clr_sel`=`4'b0100`, `o_clr_we`=1, `o_clr_addr`=1, `o_clr_wdata`=0; source drops; `o_cpu_irq` stays 0.
- `i_src_req`=`4'b1010` held continuously (re-raised after each clear), RR=1 → vec sequence 1,3,1,3. With RR=0 → 1,1,1. Without the macro: 1,1,1 and CTRL reads `16'h0001`.
- Winner 1 pending; MASK bit1 cleared in REQ without ack → `o_cpu_irq` drops, no clear issued. Repeat with ack in the same cycle → clear issued to source 1.
- `i_clr_rdy`=0 for 3 cycles in CLR → `o_clr_we` held 4 cycles. Assert `i_rst` in CLR → all outputs 0 next cycle; STATUS reads 0.
- Read PEND with `i_src_req`=`4'b0011`, MASK=`4'b0001` → `16'h0001`. With `i_re`=0 → `o_rdata`=0.
